// File: rtl/glb_packet_gen.sv
// glb_packet_gen: reads a run of words from the GLB and emits {tag, data} packets toward the GIN bus
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_start                      single-cycle job start pulse (honoured only when idle)
//   i_base_addr, i_len           first GLB address and number of words of the job
//   i_tag_start, i_tag_num       first tag and number of distinct tags before wrap (0 means 1)
//   i_words_per_tag              words sent under each tag (0 means 1)
//   o_rd_en, o_rd_addr           GLB read strobe and address
//   i_rd_data                    GLB read data, valid the cycle after o_rd_en
//   o_packet, o_valid, i_ready   {tag, data} packet stream with valid/ready handshake
//   o_busy, o_done               job active, single-cycle end-of-job pulse
module glb_packet_gen #(
    parameter int ID_BITWIDTH   = 4,
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 10,
    parameter int LEN_BITWIDTH  = 10
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [ADDR_BITWIDTH-1:0]             i_base_addr,
    input  logic [LEN_BITWIDTH-1:0]              i_len,
    input  logic [ID_BITWIDTH-1:0]               i_tag_start,
    input  logic [ID_BITWIDTH-1:0]               i_tag_num,
    input  logic [LEN_BITWIDTH-1:0]              i_words_per_tag,
    output logic                                 o_rd_en,
    output logic [ADDR_BITWIDTH-1:0]             o_rd_addr,
    input  logic [DATA_BITWIDTH-1:0]             i_rd_data,
    output logic [ID_BITWIDTH+DATA_BITWIDTH-1:0] o_packet,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic                                 o_busy,
    output logic                                 o_done
);
    localparam int PW = ID_BITWIDTH + DATA_BITWIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t                   state;
    logic [ADDR_BITWIDTH-1:0] base;
    logic [LEN_BITWIDTH-1:0]  len, wpt, issued, word_cnt;
    logic [ID_BITWIDTH-1:0]   tag_start, tag_num, tag, tag_idx, rd_tag;
    logic                     rd_v;
    logic [PW-1:0]            fifo [3];
    logic [1:0]               wr_ptr, rd_ptr, count;
    logic                     issue, pop;
    // A read issued now lands in the FIFO two edges later; counting the
    // unpopped entries plus the read already on the bus keeps the 3-entry
    // FIFO from overflowing while still allowing one read per cycle.
    always_comb begin
        issue     = state == RUN && issued != len && (3'(count) + 3'(rd_v)) <= 3'd2;
        pop       = count != 2'd0 && i_ready;
        o_rd_en   = issue;
        o_rd_addr = issue ? base + ADDR_BITWIDTH'(issued) : '0;
        o_valid   = count != 2'd0;
        o_packet  = o_valid ? fifo[rd_ptr] : '0;
        o_busy    = state != IDLE;
        o_done    = state == DONE;
    end
    always_ff @(posedge i_clk) begin
        if (rd_v) fifo[wr_ptr] <= {rd_tag, i_rd_data};
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            wpt       <= '0;
            issued    <= '0;
            word_cnt  <= '0;
            tag_start <= '0;
            tag_num   <= '0;
            tag       <= '0;
            tag_idx   <= '0;
            rd_tag    <= '0;
            rd_v      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            rd_v <= issue;
            if (issue) rd_tag <= tag;
            if (rd_v) wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
            count <= count + 2'(rd_v) - 2'(pop);
            case (state)
                IDLE: if (i_start) begin
                    base      <= i_base_addr;
                    len       <= i_len;
                    tag_start <= i_tag_start;
                    tag_num   <= i_tag_num == '0 ? ID_BITWIDTH'(1) : i_tag_num;
                    wpt       <= i_words_per_tag == '0 ? LEN_BITWIDTH'(1) : i_words_per_tag;
                    tag       <= i_tag_start;
                    tag_idx   <= '0;
                    issued    <= '0;
                    word_cnt  <= '0;
                    state     <= i_len == '0 ? DONE : RUN;
                end
                RUN: begin
                    if (issue) begin
                        issued <= issued + LEN_BITWIDTH'(1);
                        if (word_cnt == wpt - LEN_BITWIDTH'(1)) begin
                            word_cnt <= '0;
                            tag_idx  <= tag_idx == tag_num - ID_BITWIDTH'(1) ? '0 : tag_idx + ID_BITWIDTH'(1);
                            tag      <= tag_idx == tag_num - ID_BITWIDTH'(1) ? tag_start : tag + ID_BITWIDTH'(1);
                        end else begin
                            word_cnt <= word_cnt + LEN_BITWIDTH'(1);
                        end
                    end
                    if (issued == len) state <= DRAIN;
                end
                DRAIN: if (count == 2'd0 && !rd_v) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_glb_packet_gen.sv
// tb_glb_packet_gen: scoreboard bench for glb_packet_gen with a GLB memory model
module tb_glb_packet_gen;
    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [9:0]  base, len, wpt;
    logic [3:0]  ts, tn;
    logic [7:0]  rd_data;
    logic        o_rd_en, o_valid, o_busy, o_done;
    logic [9:0]  o_rd_addr;
    logic [11:0] o_packet;
    logic [7:0]  mem [1024];
    logic [11:0] exp_pkt[$], obs_pkt[$];
    logic [9:0]  exp_addr[$], obs_addr[$];
    int errors = 0, checks = 0;
    int first_rd, first_valid, last_xfer, n_done, done_cyc, stable_bad, max_out, late_rd;

    glb_packet_gen dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base), .i_len(len),
        .i_tag_start(ts), .i_tag_num(tn), .i_words_per_tag(wpt),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(rd_data),
        .o_packet(o_packet), .o_valid(o_valid), .i_ready(ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= o_rd_en ? mem[o_rd_addr] : 8'($urandom);

    task automatic gen_exp(input logic [9:0] b, input logic [9:0] l, input logic [3:0] s,
                           input logic [3:0] n, input logic [9:0] w);
        logic [3:0] tag;
        logic [9:0] a;
        int idx, wc, nn, ww;
        tag = s; idx = 0; wc = 0;
        nn = (n == 0) ? 1 : int'(n);
        ww = (w == 0) ? 1 : int'(w);
        for (int i = 0; i < int'(l); i++) begin
            a = b + 10'(i);
            exp_addr.push_back(a);
            exp_pkt.push_back({tag, mem[a]});
            wc++;
            if (wc == ww) begin
                wc = 0;
                idx++;
                if (idx == nn) begin idx = 0; tag = s; end
                else tag = tag + 4'd1;
            end
        end
    endtask

    task automatic run_job(input logic [9:0] b, input logic [9:0] l, input logic [3:0] s,
                           input logic [3:0] n, input logic [9:0] w,
                           input int st_from, input int st_len, input int restart_at, input int max_c);
        int outstanding;
        logic pv, pr;
        logic [11:0] pp;
        outstanding = 0; pv = 0; pr = 0; pp = '0;
        exp_pkt.delete(); exp_addr.delete(); obs_pkt.delete(); obs_addr.delete();
        first_rd = -1; first_valid = -1; last_xfer = -1; n_done = 0; done_cyc = -1;
        stable_bad = 0; max_out = 0; late_rd = 0;
        gen_exp(b, l, s, n, w);
        @(negedge clk);
        base = b; len = l; ts = s; tn = n; wpt = w; start = 1; ready = 1;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) begin base = b + 10'd100; len = 10'd1; ts = s + 4'd1; tn = 4'd1; wpt = 10'd1; end
            ready = !(c >= st_from && c < st_from + st_len);
            if (o_rd_en) begin
                obs_addr.push_back(o_rd_addr);
                outstanding++;
                if (first_rd < 0) first_rd = c;
                if (c >= st_from + 5 && c < st_from + st_len) late_rd++;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (pv && !pr && (!o_valid || o_packet !== pp)) stable_bad++;
            if (o_valid && first_valid < 0) first_valid = c;
            if (o_valid && ready) begin obs_pkt.push_back(o_packet); outstanding--; last_xfer = c; end
            if (o_done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            pv = o_valid; pr = ready; pp = o_packet;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start = 0; ready = 1;
    endtask

    task automatic test_reset;
        rst = 1; start = 0; ready = 1; base = '0; len = '0; ts = '0; tn = '0; wpt = '0;
        repeat (3) @(negedge clk);
        checks++; if (o_rd_en !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL reset_strobes: rd_en=%b valid=%b expected 0 0", o_rd_en, o_valid); end
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", o_busy, o_done); end
        checks++; if (o_packet !== 12'h000 || o_rd_addr !== 10'h000) begin errors++; $display("FAIL reset_data: packet=%h addr=%h expected 0 0", o_packet, o_rd_addr); end
        rst = 0;
    endtask

    task automatic test_basic;
        logic [11:0] e;
        run_job(10'h010, 10'd4, 4'd2, 4'd2, 10'd2, 0, 0, 0, 60);
        checks++; if (obs_pkt.size() != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", obs_pkt.size()); end
        for (int i = 0; i < 4; i++) begin
            e = exp_pkt.pop_front();
            checks++; if (obs_pkt.size() == 0 || obs_pkt[0] !== e) begin errors++; $display("FAIL basic_pkt[%0d]: got %h expected %h", i, obs_pkt.size() ? obs_pkt[0] : 12'h0, e); end
            if (obs_pkt.size()) void'(obs_pkt.pop_front());
        end
        checks++; if (first_rd != 1) begin errors++; $display("FAIL basic_rd_latency: got %0d expected 1", first_rd); end
        checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_valid_latency: got %0d expected 3", first_valid); end
        checks++; if (last_xfer != 6) begin errors++; $display("FAIL basic_throughput: last transfer %0d expected 6", last_xfer); end
        checks++; if (n_done != 1 || done_cyc <= last_xfer) begin errors++; $display("FAIL basic_done: count=%0d at %0d expected 1 after %0d", n_done, done_cyc, last_xfer); end
    endtask

    task automatic test_tag_wrap;
        logic [3:0] want [6];
        want = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd5, 4'd6};
        run_job(10'h123, 10'd6, 4'd5, 4'd2, 10'd1, 0, 0, 0, 60);
        checks++; if (obs_pkt.size() != 6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", obs_pkt.size()); end
        for (int i = 0; i < 6 && i < obs_pkt.size(); i++) begin
            checks++; if (obs_pkt[i][11:8] !== want[i] || obs_pkt[i] !== exp_pkt[i]) begin errors++; $display("FAIL wrap_pkt[%0d]: got %h expected %h (tag %0d)", i, obs_pkt[i], exp_pkt[i], want[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [11:0] e;
        run_job(10'h080, 10'd12, 4'd7, 4'd3, 10'd0, 5, 10, 0, 100);
        checks++; if (obs_pkt.size() != 12) begin errors++; $display("FAIL bp_count: got %0d expected 12", obs_pkt.size()); end
        for (int i = 0; i < 12; i++) begin
            e = exp_pkt.pop_front();
            checks++; if (obs_pkt.size() == 0 || obs_pkt[0] !== e) begin errors++; $display("FAIL bp_pkt[%0d]: got %h expected %h", i, obs_pkt.size() ? obs_pkt[0] : 12'h0, e); end
            if (obs_pkt.size()) void'(obs_pkt.pop_front());
        end
        checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles expected 0", stable_bad); end
        checks++; if (max_out > 3) begin errors++; $display("FAIL bp_buffered: got %0d expected at most 3", max_out); end
        checks++; if (late_rd != 0) begin errors++; $display("FAIL bp_rd_stop: %0d reads while stalled expected 0", late_rd); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_len0;
        run_job(10'h055, 10'd0, 4'd1, 4'd1, 10'd1, 0, 0, 0, 20);
        checks++; if (done_cyc != 1 || n_done != 1) begin errors++; $display("FAIL len0_done: at %0d count %0d expected at 1 count 1", done_cyc, n_done); end
        checks++; if (obs_addr.size() != 0 || obs_pkt.size() != 0) begin errors++; $display("FAIL len0_reads: reads=%0d packets=%0d expected 0 0", obs_addr.size(), obs_pkt.size()); end
    endtask

    task automatic test_addr_wrap;
        logic [9:0] want [4];
        want = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        run_job(10'h3FE, 10'd4, 4'd9, 4'd0, 10'd1, 0, 0, 0, 60);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL awrap_count: got %0d expected 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++; if (obs_addr[i] !== want[i]) begin errors++; $display("FAIL awrap_addr[%0d]: got %h expected %h", i, obs_addr[i], want[i]); end
        end
        for (int i = 0; i < 4 && i < obs_pkt.size(); i++) begin
            checks++; if (obs_pkt[i] !== exp_pkt[i] || obs_pkt[i][11:8] !== 4'd9) begin errors++; $display("FAIL awrap_pkt[%0d]: got %h expected %h", i, obs_pkt[i], exp_pkt[i]); end
        end
    endtask

    task automatic test_start_ignored;
        run_job(10'h040, 10'd8, 4'd0, 4'd4, 10'd2, 0, 0, 3, 60);
        checks++; if (obs_pkt.size() != 8 || obs_addr.size() != 8) begin errors++; $display("FAIL restart_count: packets=%0d reads=%0d expected 8 8", obs_pkt.size(), obs_addr.size()); end
        for (int i = 0; i < 8 && i < obs_pkt.size() && i < obs_addr.size(); i++) begin
            checks++; if (obs_pkt[i] !== exp_pkt[i] || obs_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL restart_pkt[%0d]: got %h@%h expected %h@%h", i, obs_pkt[i], obs_addr[i], exp_pkt[i], exp_addr[i]); end
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL restart_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_reset_in_drain;
        int bad;
        logic [11:0] e;
        @(negedge clk);
        base = 10'h100; len = 10'd3; ts = 4'd1; tn = 4'd1; wpt = 10'd1; ready = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (7) @(negedge clk);
        checks++; if (o_busy !== 1'b1 || o_valid !== 1'b1) begin errors++; $display("FAIL drain_setup: busy=%b valid=%b expected 1 1", o_busy, o_valid); end
        #2 rst = 1;
        #1;
        checks++; if ({o_valid, o_rd_en, o_busy, o_done} !== 4'b0000) begin errors++; $display("FAIL drain_rst_ctrl: got %b expected 0000", {o_valid, o_rd_en, o_busy, o_done}); end
        checks++; if (o_packet !== 12'h000 || o_rd_addr !== 10'h000) begin errors++; $display("FAIL drain_rst_data: packet=%h addr=%h expected 0 0", o_packet, o_rd_addr); end
        @(negedge clk);
        rst = 0; ready = 1; bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_valid || o_done || o_busy) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL drain_after_rst: %0d active cycles expected 0", bad); end
        run_job(10'h200, 10'd5, 4'd3, 4'd3, 10'd2, 0, 0, 0, 60);
        checks++; if (obs_pkt.size() != 5 || n_done != 1) begin errors++; $display("FAIL post_rst_job: packets=%0d done=%0d expected 5 1", obs_pkt.size(), n_done); end
        for (int i = 0; i < 5; i++) begin
            e = exp_pkt.pop_front();
            checks++; if (obs_pkt.size() == 0 || obs_pkt[0] !== e) begin errors++; $display("FAIL post_rst_pkt[%0d]: got %h expected %h", i, obs_pkt.size() ? obs_pkt[0] : 12'h0, e); end
            if (obs_pkt.size()) void'(obs_pkt.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_tag_wrap();
        test_backpressure();
        test_len0();
        test_addr_wrap();
        test_start_ignored();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/glb_packet_gen.md
GLB_PACKET_GEN -- requirements
Module: glb_packet_gen

Interface
REQ-001 SHALL have parameter ID_BITWIDTH, default 4, meaning tag field width.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 8, meaning data field width.
REQ-003 SHALL have parameter ADDR_BITWIDTH, default 10, meaning GLB read address width.
REQ-004 SHALL have parameter LEN_BITWIDTH, default 10, meaning word-count and group-size width.
REQ-005 SHALL have port i_clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-007 SHALL have port i_start, input, 1 bit, meaning a single-cycle job start pulse.
REQ-008 SHALL have port i_base_addr, input, ADDR_BITWIDTH bits, meaning the first GLB address of the job.
REQ-009 SHALL have port i_len, input, LEN_BITWIDTH bits, meaning the number of words to send.
REQ-010 SHALL have port i_tag_start, input, ID_BITWIDTH bits, meaning the first tag value.
REQ-011 SHALL have port i_tag_num, input, ID_BITWIDTH bits, meaning the number of distinct tags before wrap; 0 is treated as 1.
REQ-012 SHALL have port i_words_per_tag, input, LEN_BITWIDTH bits, meaning the number of words per tag; 0 is treated as 1.
REQ-013 SHALL have port o_rd_en, output, 1 bit, meaning GLB read strobe.
REQ-014 SHALL have port o_rd_addr, output, ADDR_BITWIDTH bits, meaning GLB read address.
REQ-015 SHALL have port i_rd_data, input, DATA_BITWIDTH bits, meaning GLB read data, valid exactly one cycle after o_rd_en.
REQ-016 SHALL have port o_packet, output, ID_BITWIDTH+DATA_BITWIDTH bits, meaning {tag, data} toward the GIN bus.
REQ-017 SHALL have port o_valid, output, 1 bit, meaning o_packet is valid.
REQ-018 SHALL have port i_ready, input, 1 bit, meaning the GIN bus accepts the packet.
REQ-019 SHALL have port o_busy, output, 1 bit, meaning a job is active.
REQ-020 SHALL have port o_done, output, 1 bit, meaning a single-cycle pulse at job end.

Function
REQ-021 SHALL implement states IDLE, RUN, DRAIN, and DONE.
REQ-022 IDLE + i_start SHALL latch all configuration inputs and move to RUN; if i_len==0 it SHALL move to DONE instead.
REQ-023 i_start outside IDLE SHALL be ignored, and the latched configuration SHALL be unaffected.
REQ-024 In RUN, the block SHALL issue a read when issued<len and (fifo_count + inflight) <= 2, where fifo_count is taken before the same-cycle pop.
REQ-025 o_rd_addr SHALL equal base_addr + issued, computed modulo 2^ADDR_BITWIDTH (address wrap allowed).
REQ-026 i_rd_data SHALL be pushed, together with the tag computed at issue time, into a 3-entry FIFO on the cycle after o_rd_en.
REQ-027 The tag SHALL start at tag_start.
REQ-028 The tag SHALL advance by 1 (mod 2^ID_BITWIDTH) after every words_per_tag words issued.
REQ-029 After tag_num distinct tags, the tag SHALL wrap back to tag_start.
REQ-030 When issued==len, the state SHALL move RUN -> DRAIN.
REQ-031 DRAIN SHALL move to DONE when the FIFO is empty and no read is in flight.
REQ-032 DONE SHALL assert o_done for exactly one cycle and then return to IDLE.
REQ-033 o_valid SHALL equal FIFO non-empty, and o_packet SHALL be the FIFO head.
REQ-034 A transfer SHALL occur on o_valid && i_ready.
REQ-035 While o_valid && !i_ready, o_packet SHALL be held stable.
REQ-036 A simultaneous push and pop SHALL leave the FIFO count unchanged; the FIFO SHALL never overflow.
REQ-037 o_busy SHALL be 1 in RUN, DRAIN, and DONE, and 0 in IDLE.
REQ-038 Latency: i_start sampled at cycle T -> o_rd_en at T+1 -> o_valid at T+3.
REQ-039 With i_ready held at 1, the block SHALL sustain 1 packet per cycle.
REQ-040 Packets SHALL leave in address order with no loss or duplication.

Reset
REQ-041 When i_rst is asserted, the block SHALL asynchronously enter IDLE, empty the FIFO, clear the counters, and drive o_valid=0, o_rd_en=0, o_busy=0, and o_done=0.
REQ-042 Reset mid-job SHALL abandon the job; read data returned after reset SHALL be discarded, and no o_done SHALL be issued.
REQ-043 During reset, o_packet and o_rd_addr SHALL be 0.

Verification
REQ-044 Basic: base=0x010, len=4, tag_start=2, tag_num=2, words_per_tag=2, i_ready=1 -> packets with tags 2,2,3,3 and data mem[0x10..0x13], one per cycle from T+3; o_done pulses once after the last transfer.
REQ-045 Tag wrap: len=6, tag_start=5, tag_num=2, words_per_tag=1 -> tags 5,6,5,6,5,6.
REQ-046 Backpressure: i_ready=0 for 10 cycles mid-job -> o_packet is stable, at most 3 packets are buffered, o_rd_en stops, and no data is lost or reordered after release.
REQ-047 Edge configurations: len=0 -> o_done at T+1 with no o_rd_en; base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-048 Control events: i_start pulsed during RUN -> ignored; i_rst asserted in DRAIN -> all outputs 0 immediately, and a following new job runs correctly.
